// File: rtl/uart_tx_wrapper.sv
// UART transmitter for 32-bit words: sends data_in as four 8N1 bytes, low byte first,
// counting completed bytes on byte_address and pulsing done when the word is finished.
module uart_tx_wrapper #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        data_valid,
    input  logic [31:0] data_in,
    output logic        ready,
    output logic        io_tx,
    output logic        done,
    output logic [31:0] byte_address
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic        tx_q, tx_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic [31:0] addr_q, addr_d;
    logic        baud_end;

    assign baud_end = (baud_q == BAUD_MAX);

    // The word is shifted right once per data bit, so word_q[0] is always the next
    // bit to send and the byte order falls out of the shift without a byte index.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (data_valid && ready_q) begin
                    word_d  = data_in;
                    state_d = START;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    baud_d  = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = word_q[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    word_d = word_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = word_q[1];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    addr_d = addr_q + 32'd1;
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = START;
                        tx_d    = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
        end
    end

    assign ready        = ready_q;
    assign io_tx        = tx_q;
    assign done         = done_q;
    assign byte_address = addr_q;

endmodule

// File: tb/tb_uart_tx_wrapper.sv
// Bench for uart_tx_wrapper at CLKS_PER_BIT=4: a line decoder fills a byte queue that is
// checked against bytes queued when each word is accepted.
module tb_uart_tx_wrapper;

    localparam int unsigned CPB = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        data_valid = 1'b0;
    logic [31:0] data_in = '0;
    logic        ready;
    logic        io_tx;
    logic        done;
    logic [31:0] byte_address;

    int checks = 0;
    int failures = 0;

    // entries are {stop_bit, data_byte}
    logic [8:0] exp_q[$];
    logic [8:0] rx_q[$];

    uart_tx_wrapper #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_valid   (data_valid),
        .data_in      (data_in),
        .ready        (ready),
        .io_tx        (io_tx),
        .done         (done),
        .byte_address (byte_address)
    );

    always #5 clk = ~clk;

    task automatic mon_wait(input int n, inout bit ab);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (reset_n !== 1'b1) ab = 1'b1;
            if (ab) return;
        end
    endtask

    // Receive-side decoder: samples each bit in the middle of its period.
    initial begin : line_monitor
        bit         ab;
        logic [8:0] f;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && io_tx === 1'b0) begin
                ab = 1'b0;
                f  = '0;
                mon_wait(CPB / 2, ab);
                for (int i = 0; i < 8 && !ab; i++) begin
                    mon_wait(CPB, ab);
                    f[i] = io_tx;
                end
                if (!ab) begin
                    mon_wait(CPB, ab);
                    f[8] = io_tx;
                end
                if (!ab) rx_q.push_back(f);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n    = 1'b0;
        data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
        exp_q.delete();
        rx_q.delete();
    endtask

    // Offers w until accepted; returns at #1 after the accepting edge.
    task automatic accept_word(input logic [31:0] w, output bit ok);
        ok         = 1'b0;
        data_valid = 1'b1;
        data_in    = w;
        for (int i = 0; i < 400; i++) begin
            if (ready === 1'b1) begin
                step();
                ok = 1'b1;
                for (int b = 0; b < 4; b++) exp_q.push_back({1'b1, w[8*b +: 8]});
                return;
            end
            step();
        end
    endtask

    task automatic wait_done(input int budget, output bit ok, output int cycles);
        ok     = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            cycles++;
            if (done === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (io_tx !== 1'b1) begin failures++; $display("FAIL reset_io_tx got=%b exp=1", io_tx); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (byte_address !== 32'd0) begin failures++; $display("FAIL reset_byte_address got=%h exp=0", byte_address); end
        apply_reset();
    endtask

    task automatic test_single();
        logic [31:0] w;
        bit          ok;
        int          bad;
        int          bi, f, p;
        logic        e;
        w = 32'h4433_2211;
        apply_reset();
        accept_word(w, ok);
        data_valid = 1'b0;
        data_in    = $urandom;
        checks++; if (!ok) begin failures++; $display("FAIL single_accept got=timeout exp=accepted"); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL single_ready_drop got=%b exp=0", ready); end
        bad = 0;
        for (int c = 0; c < 40 * CPB; c++) begin
            bi = c / CPB;
            f  = bi / 10;
            p  = bi % 10;
            e  = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : w[f*8 + p - 1];
            if (io_tx !== e) bad++;
            if (done !== 1'b0) bad++;
            step();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL single_waveform got=%0d_bad_cycles exp=0", bad); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL single_done_T161 got=%b exp=1", done); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL single_ready_at_done got=%b exp=1", ready); end
        checks++; if (byte_address !== 32'd4) begin failures++; $display("FAIL single_byte_address got=%0d exp=4", byte_address); end
        step();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done_width got=%b exp=0", done); end
        checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL single_byte_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            logic [8:0] ex, gt;
            ex = exp_q.pop_front();
            gt = rx_q.pop_front();
            checks++; if (gt !== ex) begin failures++; $display("FAIL single_byte got=%h exp=%h", gt, ex); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int c1, c2;
        apply_reset();
        accept_word(32'hDEAD_BEEF, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_accept1 got=timeout exp=accepted"); end
        data_in = 32'h0123_4567;
        c1 = 0;
        while (ready !== 1'b1 && c1 < 400) begin
            step();
            c1++;
        end
        checks++; if (c1 != 40 * CPB) begin failures++; $display("FAIL b2b_word1_cycles got=%0d exp=%0d", c1, 40 * CPB); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_accept_in_done got=%b exp=1", done); end
        for (int b = 0; b < 4; b++) exp_q.push_back({1'b1, data_in[8*b +: 8]});
        step();
        data_valid = 1'b0;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL b2b_ready2 got=%b exp=0", ready); end
        checks++; if (io_tx !== 1'b0) begin failures++; $display("FAIL b2b_no_gap got=%b exp=0", io_tx); end
        wait_done(400, ok, c2);
        checks++; if (!ok || c2 != 40 * CPB) begin failures++; $display("FAIL b2b_word2_cycles got=%0d exp=%0d", c2, 40 * CPB); end
        checks++; if (byte_address !== 32'd8) begin failures++; $display("FAIL b2b_byte_address got=%0d exp=8", byte_address); end
        checks++; if (rx_q.size() != 8 || exp_q.size() != 8) begin failures++; $display("FAIL b2b_byte_count got=%0d exp=8", rx_q.size()); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            logic [8:0] ex, gt;
            ex = exp_q.pop_front();
            gt = rx_q.pop_front();
            checks++; if (gt !== ex) begin failures++; $display("FAIL b2b_byte got=%h exp=%h", gt, ex); end
        end
    endtask

    task automatic test_ignored_valid();
        bit ok;
        int bad, dones;
        apply_reset();
        accept_word(32'h0000_0000, ok);
        data_valid = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL ign_accept got=timeout exp=accepted"); end
        bad   = 0;
        dones = 0;
        for (int i = 0; i < 50 * CPB; i++) begin
            if (i == 30) begin data_valid = 1'b1; data_in = 32'hFFFF_FFFF; end
            if (i == 31) data_valid = 1'b0;
            if (done === 1'b1) dones++;
            else if (dones == 0 && ready !== 1'b0) bad++;
            step();
        end
        checks++; if (dones != 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", dones); end
        checks++; if (bad != 0) begin failures++; $display("FAIL ign_ready_low got=%0d_bad_cycles exp=0", bad); end
        checks++; if (byte_address !== 32'd4) begin failures++; $display("FAIL ign_byte_address got=%0d exp=4", byte_address); end
        checks++; if (rx_q.size() != 4) begin failures++; $display("FAIL ign_byte_count got=%0d exp=4", rx_q.size()); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            logic [8:0] ex, gt;
            ex = exp_q.pop_front();
            gt = rx_q.pop_front();
            checks++; if (gt !== ex) begin failures++; $display("FAIL ign_byte got=%h exp=%h", gt, ex); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int cyc, bad;
        apply_reset();
        accept_word(32'h5A5A_5A5A, ok);
        data_valid = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL rmid_accept got=timeout exp=accepted"); end
        repeat (14 * CPB - 1) step();
        checks++; if (byte_address !== 32'd1) begin failures++; $display("FAIL rmid_pre_address got=%0d exp=1", byte_address); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (io_tx !== 1'b1) begin failures++; $display("FAIL rmid_io_tx got=%b exp=1", io_tx); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", ready); end
        checks++; if (byte_address !== 32'd0) begin failures++; $display("FAIL rmid_byte_address got=%0d exp=0", byte_address); end
        step();
        step();
        reset_n = 1'b1;
        exp_q.delete();
        rx_q.delete();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (io_tx !== 1'b1 || ready !== 1'b1) bad++;
            step();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rmid_no_resume got=%0d_bad_cycles exp=0", bad); end
        accept_word(32'h0000_00A5, ok);
        data_valid = 1'b0;
        wait_done(400, ok, cyc);
        checks++; if (!ok) begin failures++; $display("FAIL rmid_done got=timeout exp=done"); end
        checks++; if (byte_address !== 32'd4) begin failures++; $display("FAIL rmid_end_address got=%0d exp=4", byte_address); end
        checks++; if (rx_q.size() != 4) begin failures++; $display("FAIL rmid_byte_count got=%0d exp=4", rx_q.size()); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            logic [8:0] ex, gt;
            ex = exp_q.pop_front();
            gt = rx_q.pop_front();
            checks++; if (gt !== ex) begin failures++; $display("FAIL rmid_byte got=%h exp=%h", gt, ex); end
        end
    endtask

    task automatic test_loopback();
        bit          ok;
        int          cyc;
        logic [31:0] word;
        logic [3:0]  stops;
        apply_reset();
        accept_word(32'hCAFE_F00D, ok);
        data_valid = 1'b0;
        exp_q.delete();
        wait_done(400, ok, cyc);
        checks++; if (!ok) begin failures++; $display("FAIL loop_done got=timeout exp=done"); end
        checks++; if (rx_q.size() != 4) begin failures++; $display("FAIL loop_word_count got=%0d_bytes exp=4", rx_q.size()); end
        word  = '0;
        stops = '0;
        for (int b = 0; b < 4 && rx_q.size() > 0; b++) begin
            logic [8:0] gt;
            gt = rx_q.pop_front();
            word[8*b +: 8] = gt[7:0];
            stops[b] = gt[8];
        end
        checks++; if (word !== 32'hCAFE_F00D) begin failures++; $display("FAIL loop_data_out got=%h exp=cafef00d", word); end
        checks++; if (stops !== 4'hF) begin failures++; $display("FAIL loop_stop_bits got=%b exp=1111", stops); end
        checks++; if (byte_address !== 32'd4) begin failures++; $display("FAIL loop_byte_address got=%0d exp=4", byte_address); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignored_valid();
        test_reset_mid_frame();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
